// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, req/ready instruction fetch and next-PC selection.
// Optional MISALIGN_TRAP_EN adds fetch_misaligned and a halting TRAP state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] imm_in,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] jalr_base,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
`ifdef MISALIGN_TRAP_EN
    output logic        fetch_misaligned,
`endif
    output logic [31:0] pc_plus4
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, TRAP} state_t;
`else
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        req_q;
    logic [31:0] next_pc_d;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned_q;
`endif

    always_comb begin
        next_pc_d = pc_q + 32'd4;
        if (jalr) begin
            next_pc_d = jalr_base & 32'hFFFF_FFFE;
        end else if (jal || branch_taken) begin
            next_pc_d = pc_q + imm_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            req_q        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        pc_q <= next_pc_d;
                        if (next_pc_d[1:0] != 2'b00) begin
                            misaligned_q <= 1'b1;
                            state_q      <= TRAP;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
`else
                        pc_q    <= next_pc_d & 32'hFFFF_FFFC;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
`endif
                    end
                end
                default: begin
                    // TRAP (or any stray encoding) holds until reset
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
`ifdef MISALIGN_TRAP_EN
    assign fetch_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; covers MISALIGN_TRAP_EN when defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jal, jalr, imem_ready;
    logic [31:0] imm_in, jalr_base, imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr_out, pc_out, pc_plus4;
`ifdef MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset), .stall(stall), .imm_in(imm_in),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr), .jalr_base(jalr_base),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instr_out(instr_out), .instr_valid(instr_valid),
        .pc_out(pc_out),
`ifdef MISALIGN_TRAP_EN
        .fetch_misaligned(fetch_misaligned),
`endif
        .pc_plus4(pc_plus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect FETCH at addr a: req high, valid low.
    task automatic chk_fetch(input string tag, input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    // Expect HOLD at pc a with instruction w.
    task automatic chk_hold(input string tag, input logic [31:0] a, input logic [31:0] w);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_pc"}, pc_out, a);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr_out, w);
    endtask

    task automatic clr_ctl();
        branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0; imm_in = '0; jalr_base = '0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        clr_ctl();
        step(); step();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_instr", instr_out, 32'h13);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_plus4", pc_plus4, 32'h4);

        // BOOT cycle, then FETCH
        reset = 1'b0;
        step();
        chk_fetch("boot_to_fetch", 32'h0);

        // Sequential fetch with zero wait states
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hA000_0000 + i;
            step();
            chk_hold("seq_hold", 32'(4 * i), 32'hA000_0000 + i);
            step();
            chk_fetch("seq_fetch", 32'(4 * (i + 1)));
        end

        // Three wait states at 0x10
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_fetch("wait_fetch", 32'h10);
            chk("wait_instr", instr_out, 32'hA000_0003);
        end
        imem_ready = 1'b1; imem_rdata = 32'hB000_0010;
        step();
        chk_hold("wait_done", 32'h10, 32'hB000_0010);

        // JAL to 0x100, then branch backward to 0xF0
        jal = 1'b1; imm_in = 32'h0000_00F0;
        step();
        clr_ctl();
        chk_fetch("jal_100", 32'h100);
        imem_rdata = 32'hC000_0100;
        step();
        chk_hold("hold_100", 32'h100, 32'hC000_0100);
        branch_taken = 1'b1; imm_in = 32'hFFFF_FFF0;
        step();
        clr_ctl();
        chk_fetch("br_back", 32'hF0);
        step();
        jal = 1'b1; imm_in = 32'h20;
        step();
        clr_ctl();
        chk_fetch("jal_110", 32'h110);
        chk("plus4_110", pc_plus4, 32'h114);
        step();

        // JALR to 0x40, then jalr+jal with odd base: jalr wins, bit0 cleared
        jalr = 1'b1; jalr_base = 32'h40;
        step();
        clr_ctl();
        chk_fetch("jalr_40", 32'h40);
        imem_rdata = 32'hD000_0040;
        step();
        jalr = 1'b1; jal = 1'b1; jalr_base = 32'h1235; imm_in = 32'h8;
        step();
        clr_ctl();
        chk_fetch("jalr_prio", 32'h1234);
        imem_rdata = 32'hE000_1234;
        step();

        // Stall in HOLD: nothing moves, ready is ignored while req is low
        stall = 1'b1; imem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_hold("stall", 32'h1234, 32'hE000_1234);
        end
        stall = 1'b0;
        step();
        chk_fetch("stall_rel", 32'h1238);
        step();

`ifndef MISALIGN_TRAP_EN
        // Misaligned target gets its low bits forced to zero
        jalr = 1'b1; jalr_base = 32'h1236;
        step();
        clr_ctl();
        chk_fetch("align_force", 32'h1234);
        step();
`endif

        // Wrap: jump to 0xFFFFFFFC, then sequential to 0
        jalr = 1'b1; jalr_base = 32'hFFFF_FFFC;
        step();
        clr_ctl();
        chk_fetch("top_addr", 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step();
        step();
        chk_fetch("wrap_seq", 32'h0);
        step();

        // Reset mid-fetch at 0x200; late ready during BOOT ignored
        jalr = 1'b1; jalr_base = 32'h200;
        imem_ready = 1'b0;
        step();
        clr_ctl();
        chk_fetch("pre_rst", 32'h200);
        reset = 1'b1;
        step();
        chk("mid_rst_pc", pc_out, 32'h0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h7777_7777;
        step();
        chk_fetch("boot_ignore", 32'h0);
        chk("boot_instr", instr_out, 32'h13);

`ifdef MISALIGN_TRAP_EN
        step();
        chk("trap_pre", {31'd0, fetch_misaligned}, 32'd0);
        jalr = 1'b1; jalr_base = 32'h102;
        step();
        clr_ctl();
        chk("trap_flag", {31'd0, fetch_misaligned}, 32'd1);
        chk("trap_pc", pc_out, 32'h102);
        chk("trap_req", {31'd0, imem_req}, 32'd0);
        chk("trap_valid", {31'd0, instr_valid}, 32'd0);
        step(); step();
        chk("trap_stay_req", {31'd0, imem_req}, 32'd0);
        chk("trap_stay_flag", {31'd0, fetch_misaligned}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
